// File: rtl/btn_conditioner.sv
// Button input stage: 2-flop synchroniser, debounce FSM, and level/press/release outputs per channel.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk100,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : gen_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StArmHi, StPressed, StArmLo} state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : gen_ch
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            rep_fire;
    logic            in_hi;
    logic            cnt_done;

    assign in_hi    = sync2_q[g];
    assign cnt_done = (cnt_q == CntLast);

    always_ff @(posedge clk100) begin
      if (!reset_n) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        StIdle: begin
          if (in_hi) begin
            state_d = StArmHi;
            cnt_d   = CntW'(1);
          end
        end
        StArmHi: begin
          if (!in_hi) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!in_hi) begin
            state_d = StArmLo;
            cnt_d   = CntW'(1);
          end
        end
        StArmLo: begin
          if (in_hi) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    // Level follows the debounced state; pulses mark the debounce-complete transitions.
    always_comb begin
      level_d   = (state_d == StPressed) || (state_d == StArmLo);
      press_d   = ((state_q == StArmHi) && (state_d == StPressed)) || rep_fire;
      release_d = (state_q == StArmLo) && (state_d == StIdle);
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [RepW-1:0] rep_q, rep_d;
    logic            rep_first_q, rep_first_d;
    logic            held_q, held_d;

    assign held_q = (state_q == StPressed) || (state_q == StArmLo);
    assign held_d = (state_d == StPressed) || (state_d == StArmLo);

    always_ff @(posedge clk100) begin
      if (!reset_n) begin
        rep_q       <= '0;
        rep_first_q <= 1'b1;
      end else begin
        rep_q       <= rep_d;
        rep_first_q <= rep_first_d;
      end
    end

    // First repeat waits REPEAT_DELAY from the press, later ones REPEAT_PERIOD apart.
    always_comb begin
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
      rep_fire    = 1'b0;
      if (state_q != StPressed && state_d == StPressed) begin
        rep_d       = '0;
        rep_first_d = 1'b1;
      end else if (held_q && held_d) begin
        if (rep_q == (rep_first_q ? RepDelayLast : RepPeriodLast)) begin
          rep_fire    = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = rep_q + RepW'(1);
        end
      end else begin
        rep_d       = '0;
        rep_first_d = 1'b1;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage between the raw board buttons and the TuringMachine control inputs (Next, Done).
- Each raw button is synchronised into the clk100 domain, debounced, and turned into a clean level, a one-cycle press pulse and a one-cycle release pulse.
- The TuringMachine therefore sees exactly one Next/Done event per physical press.
- All channels are independent and identical.

Parameters:
- N_BTN, 5, number of button channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must differ from the current level before the level flips (10 ms at 100 MHz); minimum 2.
- REPEAT_DELAY, 50000000, cycles from a press pulse to the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk100  input  1  100 MHz system clock.
- reset_n  input  1  synchronous, active-low reset.
- btn_raw  input  N_BTN  asynchronous, bouncing button inputs, active high.
- btn_level  output  N_BTN  debounced button level.
- btn_press  output  N_BTN  one-cycle pulse on each debounced rising edge (plus auto-repeat pulses if enabled).
- btn_release  output  N_BTN  one-cycle pulse on each debounced falling edge.

Behaviour:
- Reset and clocking:
  - Single clock domain, clk100.
  - Reset is synchronous and active-low: sampled on the clk100 rising edge while reset_n=0.
  - Reset clears sync flops, counters and FSM state to 0 (IDLE).
  - Reset values: btn_level=0, btn_press=0, btn_release=0.
  - Reset mid-debounce or mid-press discards all progress; no pulse is emitted during reset.
- Synchroniser: two-flop chain per channel, sync1 <= btn_raw, sync2 <= sync1. Only sync2 is used downstream.
- Per-channel FSM, states IDLE, ARM_HI, PRESSED, ARM_LO:
  - IDLE (level 0): sync2=1 -> ARM_HI, cnt <= 1.
  - ARM_HI: sync2=0 -> IDLE, cnt <= 0.
  - ARM_HI: sync2=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, btn_level <= 1, btn_press <= 1 for one cycle.
  - ARM_HI: otherwise cnt <= cnt+1.
  - PRESSED (level 1): sync2=0 -> ARM_LO, cnt <= 1.
  - ARM_LO: sync2=1 -> PRESSED, cnt <= 0.
  - ARM_LO: sync2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, btn_level <= 0, btn_release <= 1 for one cycle.
  - ARM_LO: otherwise cnt <= cnt+1.
- Latency: with btn_raw held stable from edge k, btn_level changes and the pulse asserts at edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: any excursion of sync2 shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulse.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it is held or cleared by the FSM.
- All outputs are registered. btn_press and btn_release are never both high on the same channel in the same cycle.
- A button already held when reset is released is treated as a fresh press: one btn_press after the debounce period.
- Simultaneous presses on several channels are handled independently; pulses may coincide across channels.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared on entry to PRESSED.
  - While in PRESSED or ARM_LO, the repeat counter counts. It reaches REPEAT_DELAY -> extra btn_press pulse, counter reloads so the next pulse comes REPEAT_PERIOD cycles later, and so on.
  - Release debounce completing stops repeats immediately.
  - Repeat counter width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
- Undefined: exactly one btn_press per debounced press; the repeat logic and the REPEAT_* parameters are unused and synthesise away.

Test Plan:
- Bench config for all scenarios: N_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold reset_n=0 for 3 cycles with btn_raw=2'b11 -> btn_level=0, btn_press=0 and btn_release=0 throughout. After release, btn_level=2'b11 and btn_press=2'b11 for exactly one cycle, 5 edges after the first post-reset sample.
- Clean press: raw[0] 0->1 sampled at edge 10 and held -> btn_level[0]=1 and btn_press[0]=1 at edge 15, btn_press[0]=0 at edge 16.
- Bounce: raw[0] toggles 1,0,1,1,0,1 on consecutive cycles, then stays 1 -> no pulse during the bounce; exactly one btn_press[0] 5 cycles after the final stable 1 is sampled.
- Glitch on release: from PRESSED, raw[0]=0 for 3 cycles then back to 1 -> btn_level[0] stays 1, btn_release[0] never asserts.
- Release: from PRESSED, raw[0]=0 held -> btn_level[0] falls and btn_release[0]=1 for one cycle, 5 edges after the first 0 sample. Channel 1 is unaffected throughout.
- Auto-repeat (macro defined): hold raw[1]=1 for 30 cycles past the press -> extra btn_press[1] pulses at press+10, +13, +16, ... until the release debounce completes. With the macro undefined, a single btn_press[1] pulse only.
